imem_responder: RTL and testbench

Instruction-memory responder that serves the fetch stage's PC-addressed read requests. It answers each accepted request with the instruction word after a fixed, parameterised latency. It sits between fetch and a word-addressed instruction store held inside the block, and it owns a program-load write port used by the boot loader. The block supports one-per-cycle throughput, response back-pressure, and flush of in-flight reads on a taken jump or branch.

---
 rtl/imem_responder_if.sv | 35 +++
 rtl/imem_responder.sv | 73 +++++++
 tb/tb_imem_responder.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_responder_if
// Description : Fetch-side request/response, flush and program-load bundle
//               for the instruction-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_responder_if #(
    parameter int ADDR_W = 8
) ();
    logic              req_valid;
    logic [15:0]       req_addr;
    logic              req_ready;
    logic              flush;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [15:0]       rsp_data;
    logic [15:0]       rsp_addr;
    logic              rsp_err;
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [15:0]       ld_data;
    logic              busy;

    modport master (
        output req_valid, req_addr, flush, rsp_ready, ld_en, ld_addr, ld_data,
        input  req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_addr, flush, rsp_ready, ld_en, ld_addr, ld_data,
        output req_ready, rsp_valid, rsp_data, rsp_addr, rsp_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// ============================================================================
// Module      : imem_responder
// Description : Fixed-latency instruction store responder with back-pressure,
//               flush of in-flight reads and a program-load write port.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  wire logic           clk,
    input  wire logic           rst,
    imem_responder_if.slave     bus
);
    localparam int c_DEPTH = 1 << ADDR_W;

    logic [15:0]               r_mem [c_DEPTH];
    logic [LATENCY-1:0]        r_vld;
    logic [LATENCY-1:0]        r_err;
    logic [LATENCY-1:0][15:0]  r_addr;
    logic [LATENCY-1:0][15:0]  r_data;

    logic        w_stall;
    logic        w_req_ready;
    logic        w_accept;
    logic        w_oob;
    logic [15:0] w_rd_data;

    // A flush must still admit the redirect request even while the head is stalled.
    always_comb begin
        w_stall     = r_vld[LATENCY-1] & ~bus.rsp_ready;
        w_req_ready = rst & ~bus.ld_en & (bus.flush | ~w_stall);
        w_accept    = bus.req_valid & w_req_ready;
        w_oob       = (bus.req_addr >> ADDR_W) != 16'd0;
        w_rd_data   = w_oob ? 16'h0000 : r_mem[bus.req_addr[ADDR_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (bus.ld_en) begin
            r_mem[bus.ld_addr] <= bus.ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vld  <= '0;
            r_err  <= '0;
            r_addr <= '0;
            r_data <= '0;
        end else if (bus.flush || !w_stall) begin
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i]  <= bus.flush ? 1'b0 : r_vld[i-1];
                r_err[i]  <= r_err[i-1];
                r_addr[i] <= r_addr[i-1];
                r_data[i] <= r_data[i-1];
            end
            r_vld[0]  <= w_accept;
            r_err[0]  <= w_oob;
            r_addr[0] <= bus.req_addr;
            r_data[0] <= w_rd_data;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_vld[LATENCY-1];
    assign bus.rsp_data  = r_data[LATENCY-1];
    assign bus.rsp_addr  = r_addr[LATENCY-1];
    assign bus.rsp_err   = r_err[LATENCY-1];
    assign bus.busy      = |r_vld;

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_responder
// Description : Scoreboard-based self-checking bench for imem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_responder;
    localparam int ADDR_W = 8;
    localparam int LAT    = 2;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    imem_responder_if #(.ADDR_W(ADDR_W)) bus ();
    imem_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          vectors    = 0;
    int          miscompares = 0;
    bit          mon_en     = 1'b0;
    exp_t        sb[$];
    exp_t        head;
    exp_t        pushed;
    logic [15:0] mdl [256];

    // Scoreboard: push on request handshake, pop on response handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.rsp_valid && sb.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL sb_spurious: rsp_valid=1 addr=%h with no request outstanding", bus.rsp_addr);
            end else if (bus.rsp_valid && bus.rsp_ready) begin
                head = sb.pop_front();
                vectors++;
                if ({bus.rsp_addr, bus.rsp_data, bus.rsp_err} !== head) begin
                    miscompares++;
                    $display("FAIL sb_rsp: got addr=%h data=%h err=%b want addr=%h data=%h err=%b",
                             bus.rsp_addr, bus.rsp_data, bus.rsp_err, head.addr, head.data, head.err);
                end
            end
            if (!rst || bus.flush) sb.delete();
            if (rst && bus.req_valid && bus.req_ready) begin
                pushed.addr = bus.req_addr;
                pushed.err  = (bus.req_addr[15:8] != 8'h00);
                pushed.data = pushed.err ? 16'h0000 : mdl[bus.req_addr[7:0]];
                sb.push_back(pushed);
            end
            if (bus.ld_en) mdl[bus.ld_addr] = bus.ld_data;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid = 1'b0;
        bus.req_addr  = 16'h0000;
        bus.flush     = 1'b0;
        bus.rsp_ready = 1'b1;
        bus.ld_en     = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_data   = 16'h0000;
    endtask

    task automatic drain(input string name);
        idle();
        for (int i = 0; i < 20 && sb.size() != 0; i++) cyc();
        cyc();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: %0d responses outstanding, want 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        bus.req_valid = 1'b1;
        cyc(); cyc();
        @(negedge clk);
        vectors += 6;
        if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        if (bus.rsp_data !== 16'h0000) begin miscompares++; $display("FAIL reset_rsp_data: got %h want 0000", bus.rsp_data); end
        if (bus.rsp_addr !== 16'h0000) begin miscompares++; $display("FAIL reset_rsp_addr: got %h want 0000", bus.rsp_addr); end
        if (bus.rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_err: got %b want 0", bus.rsp_err); end
        if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); end
        cyc();
        bus.req_valid = 1'b0;
        rst = 1'b1;
        mon_en = 1'b1;
        #1;
        vectors++;
        if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL release_req_ready: got %b want 1", bus.req_ready); end
        cyc();
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        for (int i = 0; i < 4; i++) begin
            bus.ld_en = 1'b1; bus.ld_addr = 8'(i); bus.ld_data = 16'h1111 + 16'(i);
            cyc();
        end
        bus.ld_en = 1'b0;
        for (int c = 0; c < 8; c++) begin
            bus.req_valid = (c < 4);
            bus.req_addr  = 16'(c);
            @(negedge clk);
            if (c < 4) begin
                vectors++;
                if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_req_ready: step %0d got %b want 1", c, bus.req_ready); end
            end
            exp_v = (c >= LAT && c < LAT + 4);
            vectors++;
            if (bus.rsp_valid !== exp_v) begin miscompares++; $display("FAIL b2b_rsp_valid: step %0d got %b want %b", c, bus.rsp_valid, exp_v); end
            if (exp_v) begin
                vectors += 2;
                if (bus.rsp_addr !== 16'(c - LAT)) begin miscompares++; $display("FAIL b2b_rsp_addr: step %0d got %h want %h", c, bus.rsp_addr, 16'(c - LAT)); end
                if (bus.rsp_data !== 16'h1111 + 16'(c - LAT)) begin miscompares++; $display("FAIL b2b_rsp_data: step %0d got %h want %h", c, bus.rsp_data, 16'h1111 + 16'(c - LAT)); end
            end
            cyc();
        end
        drain("b2b");
    endtask

    task automatic test_stall();
        int nxt = 0;
        for (int c = 0; c < 10; c++) begin
            bus.req_valid = (nxt < 3);
            bus.req_addr  = 16'(nxt);
            bus.rsp_ready = !(c >= 2 && c <= 4);
            @(negedge clk);
            if (c >= 2 && c <= 5) begin
                vectors += 2;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h1111) begin
                    miscompares++; $display("FAIL stall_hold: step %0d got valid=%b data=%h want 1/1111", c, bus.rsp_valid, bus.rsp_data);
                end
                if (c <= 4 && bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL stall_req_ready: step %0d got %b want 0", c, bus.req_ready); end
                if (c == 5 && bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL stall_release_ready: got %b want 1", bus.req_ready); end
            end
            if (c == 6 || c == 7) begin
                vectors++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h1112 + 16'(c - 6)) begin
                    miscompares++; $display("FAIL stall_resume: step %0d got valid=%b data=%h want 1/%h", c, bus.rsp_valid, bus.rsp_data, 16'h1112 + 16'(c - 6));
                end
            end
            if (bus.req_valid && bus.req_ready) nxt++;
            cyc();
        end
        drain("stall");
    endtask

    task automatic test_flush();
        for (int c = 0; c < 6; c++) begin
            idle();
            bus.req_valid = (c <= 2);
            bus.req_addr  = (c == 2) ? 16'h0003 : 16'(c);
            bus.flush     = (c == 2);
            bus.rsp_ready = (c != 2);
            @(negedge clk);
            if (c == 2) begin
                vectors++;
                if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL flush_req_ready: got %b want 1", bus.req_ready); end
            end
            if (c == 3 || c == 5) begin
                vectors++;
                if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL flush_quiet: step %0d got rsp_valid=%b want 0", c, bus.rsp_valid); end
            end
            if (c == 4) begin
                vectors++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_addr !== 16'h0003 || bus.rsp_data !== 16'h1114) begin
                    miscompares++; $display("FAIL flush_redirect: got valid=%b addr=%h data=%h want 1/0003/1114", bus.rsp_valid, bus.rsp_addr, bus.rsp_data);
                end
            end
            cyc();
        end
        for (int c = 0; c < 3; c++) begin
            idle();
            bus.req_valid = (c == 0);
            bus.flush     = (c == 1);
            @(negedge clk);
            if (c == 1) begin
                vectors++;
                if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL flush_busy_before: got %b want 1", bus.busy); end
            end
            if (c == 2) begin
                vectors++;
                if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
                    miscompares++; $display("FAIL flush_empty: got valid=%b busy=%b want 0/0", bus.rsp_valid, bus.busy);
                end
            end
            cyc();
        end
        drain("flush");
    endtask

    task automatic test_oob();
        bus.ld_en = 1'b1; bus.ld_addr = 8'hFF; bus.ld_data = 16'hABCD;
        cyc();
        for (int c = 0; c < 5; c++) begin
            idle();
            bus.req_valid = (c < 2);
            bus.req_addr  = (c == 0) ? 16'h00FF : 16'h0100;
            @(negedge clk);
            if (c == 2) begin
                vectors++;
                if (bus.rsp_data !== 16'hABCD || bus.rsp_err !== 1'b0) begin
                    miscompares++; $display("FAIL oob_last_in_range: got data=%h err=%b want abcd/0", bus.rsp_data, bus.rsp_err);
                end
            end
            if (c == 3) begin
                vectors++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_data !== 16'h0000 || bus.rsp_addr !== 16'h0100) begin
                    miscompares++; $display("FAIL oob_wrap: got valid=%b err=%b data=%h addr=%h want 1/1/0000/0100",
                                            bus.rsp_valid, bus.rsp_err, bus.rsp_data, bus.rsp_addr);
                end
            end
            cyc();
        end
        drain("oob");
    endtask

    task automatic test_load_conflict();
        for (int c = 0; c < 6; c++) begin
            idle();
            bus.req_valid = (c <= 2);
            bus.req_addr  = 16'h0005;
            bus.ld_en     = (c < 2);
            bus.ld_addr   = 8'h05;
            bus.ld_data   = 16'h5A5A;
            @(negedge clk);
            if (c < 2) begin
                vectors++;
                if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL load_blocks_req: step %0d got %b want 0", c, bus.req_ready); end
            end
            if (c == 4) begin
                vectors++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h5A5A) begin
                    miscompares++; $display("FAIL load_lands: got valid=%b data=%h want 1/5a5a", bus.rsp_valid, bus.rsp_data);
                end
            end
            cyc();
        end
        for (int c = 0; c < 6; c++) begin
            idle();
            bus.req_valid = (c == 0 || c == 3);
            bus.req_addr  = 16'h0001;
            bus.ld_en     = (c == 1);
            bus.ld_addr   = 8'h01;
            bus.ld_data   = 16'h7777;
            @(negedge clk);
            if (c == 2 || c == 5) begin
                vectors++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== ((c == 2) ? 16'h1112 : 16'h7777)) begin
                    miscompares++; $display("FAIL load_inflight: step %0d got valid=%b data=%h want 1/%h", c, bus.rsp_valid, bus.rsp_data,
                                            (c == 2) ? 16'h1112 : 16'h7777);
                end
            end
            cyc();
        end
        drain("load");
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 8; c++) begin
            idle();
            bus.req_valid = (c <= 1 || c == 4);
            bus.req_addr  = (c == 1) ? 16'h0002 : 16'h0000;
            bus.rsp_ready = (c != 2);
            rst           = (c != 2);
            @(negedge clk);
            if (c == 2) begin
                vectors++;
                if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL rstmid_busy_before: got %b want 1", bus.busy); end
            end
            if (c == 3) begin
                vectors++;
                if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
                    miscompares++; $display("FAIL rstmid_clear: got valid=%b busy=%b want 0/0", bus.rsp_valid, bus.busy);
                end
            end
            if (c == 6) begin
                vectors++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 16'h1111) begin
                    miscompares++; $display("FAIL rstmid_mem_kept: got valid=%b data=%h want 1/1111", bus.rsp_valid, bus.rsp_data);
                end
            end
            cyc();
        end
        drain("rstmid");
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mdl[i] = 16'h0000;
        test_reset();
        test_back_to_back();
        test_stall();
        test_flush();
        test_oob();
        test_load_conflict();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
